// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and defaults for the ALU command responder.
package alu_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_RST = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    // 101 and 110 are the only unassigned encodings
    function automatic logic is_legal_op(input logic [2:0] op);
        return op != 3'b101 && op != 3'b110;
    endfunction

endpackage

// File: rtl/alu_cmd_responder_if.sv
// alu_cmd_responder_if: start/done ALU command bus; err exists only when ALU_ERR_EN is defined.
interface alu_cmd_responder_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic                start;
    logic [2:0]          op;
    logic [DATA_W-1:0]   A;
    logic [DATA_W-1:0]   B;
    logic                done;
    logic [2*DATA_W-1:0] result;
`ifdef ALU_ERR_EN
    logic                err;

    modport master (output start, op, A, B, input done, result, err);
    modport slave  (input start, op, A, B, output done, result, err);
`else
    modport master (output start, op, A, B, input done, result);
    modport slave  (input start, op, A, B, output done, result);
`endif
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add unsigned multiplier; the load edge performs the first of DATA_W steps.
module alu_seq_mul #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                last,
    output logic [2*DATA_W-1:0] product
);
    localparam int RW = 2 * DATA_W;
    localparam int CW = $clog2(DATA_W) + 1;

    logic [RW-1:0]     acc;
    logic [RW-1:0]     mcand;
    logic [DATA_W-1:0] mplier;
    logic [CW-1:0]     cnt;

    // product is the accumulator after the current step, so it is valid on the edge where last is high
    always_comb begin
        product = acc + (mplier[0] ? mcand : '0);
        last    = busy && cnt == CW'(DATA_W - 1);
    end

    // consume one multiplier bit per cycle; reset discards any partial product
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (load) begin
            acc    <= b[0] ? RW'(a) : '0;
            mcand  <= RW'(a) << 1;
            mplier <= b >> 1;
            cnt    <= CW'(1);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            busy   <= !last;
        end
    end
endmodule

// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder: start/done ALU responder; define ALU_ERR_EN to flag illegal opcodes on err.
module alu_cmd_responder
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input logic                clk,
    input logic                reset,
    alu_cmd_responder_if.slave bus
);
    localparam int RW = 2 * DATA_W;

    state_t        state;
    logic          done_q;
    logic [RW-1:0] result_q;
    logic [RW-1:0] alu_res;
    logic [RW-1:0] product;
    logic          mul_load;
    logic          mul_busy;
    logic          mul_last;
`ifdef ALU_ERR_EN
    logic          err_q;

    assign bus.err = err_q;
`endif

    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign mul_load   = state == IDLE && bus.start && bus.op == OP_MUL;

    // single-cycle ops evaluated straight from the bus on the accept edge; no_op and illegal ops hold
    always_comb begin
        alu_res = !is_legal_op(bus.op) ? result_q :
                  bus.op == OP_ADD     ? RW'(bus.A) + RW'(bus.B) :
                  bus.op == OP_AND     ? RW'(bus.A & bus.B) :
                  bus.op == OP_XOR     ? RW'(bus.A ^ bus.B) :
                  bus.op == OP_RST     ? '0 : result_q;
    end

    alu_seq_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .a       (bus.A),
        .b       (bus.B),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (product)
    );

    // accept in IDLE, iterate in MUL, then spend exactly one cycle in DONE with done high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef ALU_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef ALU_ERR_EN
            err_q  <= 1'b0;
`endif
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.op == OP_MUL) begin
                        state <= MUL;
                    end else begin
                        result_q <= alu_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
`ifdef ALU_ERR_EN
                        err_q    <= !is_legal_op(bus.op);
`endif
                    end
                end
                MUL: if (mul_last) begin
                    result_q <= product;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end else if (!mul_busy) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_responder.sv
// tb_alu_cmd_responder: directed and random checks of the ALU responder against a behavioural model.
module tb_alu_cmd_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails = 0;
    logic [15:0] model_res = 16'h0000;

    alu_cmd_responder_if #(.DATA_W(8)) bus ();

    alu_cmd_responder #(.DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                          input logic [15:0] prev);
        int unsigned x, y;
        x = a;
        y = b;
        case (o)
            3'd1:    return 16'(x + y);
            3'd2:    return 16'(x & y);
            3'd3:    return 16'(x ^ y);
            3'd4:    return 16'(x * y);
            3'd7:    return 16'd0;
            default: return prev;
        endcase
    endfunction

    // issue one command, scramble the bus after acceptance, report what came back
    task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, output int lat,
                        output logic [15:0] res, output logic e, output logic stray, output logic after);
        @(negedge clk);
        bus.op = o;
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        lat = 0;
        e = 1'b0;
        stray = 1'b0;
        do begin
            @(negedge clk);
            lat++;
`ifdef ALU_ERR_EN
            if (!bus.done && bus.err) stray = 1'b1;
`endif
            bus.op = 3'($urandom);
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
        end while (!bus.done && lat < 40);
        res = bus.result;
`ifdef ALU_ERR_EN
        e = bus.err;
`endif
        bus.start = 1'b0;
        @(negedge clk);
        after = bus.done;
`ifdef ALU_ERR_EN
        if (bus.err) stray = 1'b1;
`endif
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.op = 3'd1;
        bus.A = 8'h01;
        bus.B = 8'h02;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.result !== 16'h0000) begin
                fails++;
                $display("FAIL reset_hold: done=%b result=%h, required done=0 result=0000", bus.done, bus.result);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0003) begin
            fails++;
            $display("FAIL reset_first_accept: done=%b result=%h, required done=1 result=0003", bus.done, bus.result);
        end
        bus.start = 1'b0;
        model_res = 16'h0003;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[3] = '{3'd1, 3'd2, 3'd3};
        logic [7:0]  as[3] = '{8'hFF, 8'hF0, 8'hF0};
        logic [7:0]  bs[3] = '{8'hFF, 8'h3C, 8'h3C};
        logic [15:0] exp[3] = '{16'h01FE, 16'h0030, 16'h00CC};
        int idx = 0;
        @(negedge clk);
        bus.op = ops[0];
        bus.A = as[0];
        bus.B = bs[0];
        bus.start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== ((k % 2) == 1)) begin
                fails++;
                $display("FAIL b2b_done cycle %0d: done=%b, required %b", k, bus.done, (k % 2) == 1);
            end
            if (bus.done === 1'b1 && idx < 3) begin
                checks++;
                if (bus.result !== exp[idx]) begin
                    fails++;
                    $display("FAIL b2b_result %0d: result=%h, required %h", idx, bus.result, exp[idx]);
                end
                idx++;
                if (idx < 3) begin
                    bus.op = ops[idx];
                    bus.A = as[idx];
                    bus.B = bs[idx];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        model_res = 16'h00CC;
    endtask

    task automatic test_mul();
        int lat;
        logic [15:0] res;
        logic e, stray, after;
        send(3'd4, 8'hFF, 8'hFF, lat, res, e, stray, after);
        checks++;
        if (lat !== 8 || res !== 16'hFE01 || after !== 1'b0) begin
            fails++;
            $display("FAIL mul_ff: lat=%0d result=%h done_after=%b, required lat=8 result=FE01 done_after=0", lat, res, after);
        end
        send(3'd4, 8'h00, 8'h37, lat, res, e, stray, after);
        checks++;
        if (lat !== 8 || res !== 16'h0000) begin
            fails++;
            $display("FAIL mul_zero: lat=%0d result=%h, required lat=8 result=0000", lat, res);
        end
        model_res = 16'h0000;
    endtask

    task automatic test_rst_nop();
        int lat;
        logic [15:0] res;
        logic e, stray, after;
        send(3'd1, 8'hFF, 8'hFF, lat, res, e, stray, after);
        checks++;
        if (res !== 16'h01FE || lat !== 1) begin
            fails++;
            $display("FAIL pre_rst_add: lat=%0d result=%h, required lat=1 result=01FE", lat, res);
        end
        send(3'd7, 8'h12, 8'h34, lat, res, e, stray, after);
        checks++;
        if (res !== 16'h0000 || lat !== 1 || after !== 1'b0) begin
            fails++;
            $display("FAIL rst_op: lat=%0d result=%h done_after=%b, required lat=1 result=0000 done_after=0", lat, res, after);
        end
        send(3'd0, 8'h56, 8'h78, lat, res, e, stray, after);
        checks++;
        if (res !== 16'h0000 || lat !== 1) begin
            fails++;
            $display("FAIL no_op: lat=%0d result=%h, required lat=1 result=0000", lat, res);
        end
        model_res = 16'h0000;
    endtask

    task automatic test_mul_abort();
        int lat;
        logic [15:0] res;
        logic e, stray, after;
        logic seen = 1'b0;
        send(3'd2, 8'hF0, 8'h3C, lat, res, e, stray, after);
        @(negedge clk);
        bus.op = 3'd4;
        bus.A = 8'hFF;
        bus.B = 8'hFF;
        bus.start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        reset = 1'b1;
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.result !== 16'h0000 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: done=%b result=%h, required done=0 result=0000", bus.done, bus.result);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.result !== 16'h0000) begin
            fails++;
            $display("FAIL abort_no_done: done_seen=%b result=%h, required done_seen=0 result=0000", seen, bus.result);
        end
        send(3'd1, 8'h01, 8'h02, lat, res, e, stray, after);
        checks++;
        if (lat !== 1 || res !== 16'h0003) begin
            fails++;
            $display("FAIL abort_next_add: lat=%0d result=%h, required lat=1 result=0003", lat, res);
        end
        model_res = 16'h0003;
    endtask

    task automatic test_illegal();
        int lat;
        logic [15:0] res;
        logic e, stray, after;
        send(3'd5, 8'hAA, 8'h55, lat, res, e, stray, after);
        checks++;
        if (lat !== 1 || res !== 16'h0003) begin
            fails++;
            $display("FAIL illegal_hold: lat=%0d result=%h, required lat=1 result=0003", lat, res);
        end
`ifdef ALU_ERR_EN
        checks++;
        if (e !== 1'b1 || stray !== 1'b0) begin
            fails++;
            $display("FAIL illegal_err: err_at_done=%b err_elsewhere=%b, required 1 and 0", e, stray);
        end
        send(3'd1, 8'h01, 8'h01, lat, res, e, stray, after);
        checks++;
        if (e !== 1'b0 || stray !== 1'b0 || res !== 16'h0002) begin
            fails++;
            $display("FAIL legal_no_err: err=%b stray=%b result=%h, required 0 0 0002", e, stray, res);
        end
        model_res = 16'h0002;
`endif
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] res, exp;
        logic e, stray, after;
        logic [2:0] o;
        logic [7:0] a, b;
        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            exp = model(o, a, b, model_res);
            send(o, a, b, lat, res, e, stray, after);
            checks++;
            if (res !== exp || lat !== (o == 3'd4 ? 8 : 1) || after !== 1'b0) begin
                fails++;
                $display("FAIL random %0d op=%0d a=%h b=%h: result=%h lat=%0d done_after=%b, required result=%h lat=%0d done_after=0",
                         n, o, a, b, res, lat, after, exp, (o == 3'd4 ? 8 : 1));
            end
`ifdef ALU_ERR_EN
            checks++;
            if (e !== (o == 3'd5 || o == 3'd6) || stray !== 1'b0) begin
                fails++;
                $display("FAIL random_err %0d op=%0d: err=%b stray=%b, required err=%b stray=0", n, o, e, stray, (o == 3'd5 || o == 3'd6));
            end
`endif
            model_res = exp;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.A = 8'h00;
        bus.B = 8'h00;
        test_reset();
        test_back_to_back();
        test_mul();
        test_rst_nop();
        test_mul_abort();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
